// File: rtl/proc_sequencer_if.sv
// Host/processor-side bundle for proc_sequencer: push channel, flush/step controls and issue status.
interface proc_sequencer_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [15:0]              in_instr;
  logic                     flush;
  logic                     step;
  logic [15:0]              proc_iin;
  logic                     busy;
  logic                     instr_done;
  logic                     illegal;
  logic [15:0]              retired_cnt;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output in_valid, in_instr, flush, step,
    input  in_ready, proc_iin, busy, instr_done, illegal, retired_cnt, fifo_count
  );

  modport slave (
    input  in_valid, in_instr, flush, step,
    output in_ready, proc_iin, busy, instr_done, illegal, retired_cnt, fifo_count
  );
endinterface

// File: rtl/proc_sequencer.sv
// proc_sequencer: FIFO-fed instruction issue controller holding each word on proc_iin for its opcode's cycle count.
// Optional feature macro SEQ_STEP_EN: each word issue additionally waits for the step input.
module proc_sequencer #(
  parameter int          DEPTH      = 4,
  parameter int          MV_CYCLES  = 2,
  parameter int          ALU_CYCLES = 4,
  parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
  input  logic             clk,
  input  logic             resetn,
  proc_sequencer_if.slave  bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int MAXL = (MV_CYCLES > ALU_CYCLES) ? MV_CYCLES : ALU_CYCLES;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, EXEC} state_t;

  // Counter preload is L-1 so instr_done lands on the L-th cycle.
  function automatic logic [CW-1:0] hold_of(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: return CW'(MV_CYCLES - 1);
      3'b010, 3'b011: return CW'(ALU_CYCLES - 1);
      default:        return '0;
    endcase
  endfunction

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_inc, rd_nxt;
  logic [PW:0]   count;
  logic [CW-1:0] hold;
  logic [15:0]   retired;
  state_t        state, state_nxt;
  logic          full, push, retire, load, keep, go;
  logic [15:0]   load_word;

`ifdef SEQ_STEP_EN
  assign go = bus.step;
`else
  logic step_unused;
  assign go          = 1'b1;
  assign step_unused = bus.step;
`endif

  assign full   = (count == CNT_FULL);
  assign push   = bus.in_valid && !full && !bus.flush;
  assign retire = (state == EXEC) && (hold == '0);
  assign rd_inc = rd_ptr + PW'(1);
  assign rd_nxt = retire ? rd_inc : rd_ptr;
  // Flush keeps only a head that is still executing after this edge.
  assign keep   = (state == EXEC) && !retire;

  assign bus.in_ready    = !full;
  assign bus.retired_cnt = retired;
  assign bus.fifo_count  = count;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Follow-on word must already be queued before the retire edge.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_word = mem[rd_ptr];
    case (state)
      IDLE: begin
        if (count != '0 && !bus.flush && go) begin
          state_nxt = EXEC;
          load      = 1'b1;
        end
      end
      EXEC: begin
        if (retire) begin
          load_word = mem[rd_inc];
          if (count > CNT_ONE && !bus.flush && go) load = 1'b1;
          else                                     state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.proc_iin   = IDLE_WORD;
    bus.busy       = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    if (state == EXEC) begin
      bus.proc_iin   = mem[rd_ptr];
      bus.busy       = 1'b1;
      bus.instr_done = (hold == '0);
      bus.illegal    = mem[rd_ptr][15];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      hold    <= '0;
      retired <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      if (bus.flush) begin
        wr_ptr <= rd_nxt + PW'(keep);
        count  <= (PW+1)'(keep);
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        case ({push, retire})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
      if (retire) retired <= retired + 16'd1;
      if (load)                             hold <= hold_of(load_word[15:13]);
      else if (state == EXEC && hold != '0) hold <= hold - CW'(1);
    end
  end
endmodule
